// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : clocked, parametrised arithmetic unit between the register file
//           and the writeback stage.
//
// Operands and opcode are captured on a start/busy handshake. The unit
// returns a registered result plus carry/overflow/zero flags, with a
// one-cycle `done` pulse. Opcode 111 is a multi-cycle unsigned shift-add
// multiply. It is built only when the macro ALU_SEQ_MUL_EN is defined.
// Without the macro, opcode 111 completes in one cycle with a zero result.
//
// Ports
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, accepted when the unit is not busy
//   S      in  3      opcode
//   A, B   in  WIDTH  operands
//   Y      out WIDTH  result (multiply: low half)
//   Y_HI   out WIDTH  multiply high half, 0 for every other opcode
//   C      out 1      carry / borrow
//   V      out 1      signed overflow
//   Z      out 1      zero flag
//   busy   out 1      multiply in progress
//   done   out 1      one-cycle pulse, outputs updated on the same edge
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_HI,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_INV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DBL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             v;
    } res_t;

    // Single-cycle opcodes. Opcode 111 falls to the default (all zero). With
    // the multiplier built, that path is never registered for 111.
    function automatic res_t alu_op(input logic [2:0]       op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        res_t                    r;
        logic        [WIDTH:0]   u_ext;
        logic signed [WIDTH:0]   s_ext;
        r     = '0;
        u_ext = '0;
        s_ext = '0;
        case (op)
            OP_INV: r.y = ~a;
            OP_ADD: begin
                u_ext = {1'b0, a} + {1'b0, b};
                s_ext = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
                r.y   = u_ext[WIDTH-1:0];
                r.c   = u_ext[WIDTH];
                // Sign-extended sum disagrees in its top two bits on overflow.
                r.v   = s_ext[WIDTH] ^ s_ext[WIDTH-1];
            end
            OP_SUB: begin
                // Zero-extended difference goes negative exactly when a < b.
                u_ext = {1'b0, a} - {1'b0, b};
                s_ext = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
                r.y   = u_ext[WIDTH-1:0];
                r.c   = u_ext[WIDTH];
                r.v   = s_ext[WIDTH] ^ s_ext[WIDTH-1];
            end
            OP_DBL: begin
                r.y = {a[WIDTH-2:0], 1'b0};
                r.c = a[WIDTH-1];
                r.v = a[WIDTH-1] ^ a[WIDTH-2];
            end
            OP_AND:  r.y = a & b;
            OP_OR:   r.y = a | b;
            OP_XOR:  r.y = a ^ b;
            default: r   = '0;
        endcase
        return r;
    endfunction

    // Captured request. Pure data, so it carries no reset.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;

    // Control and registered outputs.
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] yhi_q, yhi_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic             accept;
    res_t             sc_res;

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Upper half is the running partial product. Lower half starts as the
    // multiplier and is shifted out one bit per step.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   acc_wide;
    logic               mul_last;

    assign mul_last = (state_q == ST_MUL) && (cnt_q == CNT_W'(1));
    // The last multiply edge also accepts a new request, so throughput is
    // one multiply per WIDTH cycles.
    assign accept   = start && ((state_q == ST_IDLE) || mul_last);
    assign busy     = (state_q == ST_MUL);

    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        acc_wide  = {upper_sum, acc_q[WIDTH-1:0]};
        acc_step  = acc_wide[2*WIDTH:1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (S == OP_MUL)) begin
                    state_d = ST_MUL;
                    cnt_d   = CNT_W'(WIDTH);
                    acc_d   = {{WIDTH{1'b0}}, B};
                end
            end
            ST_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (mul_last) begin
                    state_d = ST_IDLE;
                    if (accept && (S == OP_MUL)) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, B};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign pend_d = accept && (S != OP_MUL);
`else
    assign accept = start;
    assign busy   = 1'b0;
    assign pend_d = accept;
`endif

    // Stage 1: capture the request.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= S;
        end
    end

    assign sc_res = alu_op(op_q, a_q, b_q);

    // Stage 2: evaluate the captured single-cycle op, or retire the multiply.
    always_comb begin
        y_d    = y_q;
        yhi_d  = yhi_q;
        c_d    = c_q;
        v_d    = v_q;
        z_d    = z_q;
        done_d = 1'b0;
        if (pend_q) begin
            y_d    = sc_res.y;
            yhi_d  = '0;
            c_d    = sc_res.c;
            v_d    = sc_res.v;
            z_d    = (sc_res.y == '0);
            done_d = 1'b1;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (mul_last) begin
            y_d    = acc_step[WIDTH-1:0];
            yhi_d  = acc_step[2*WIDTH-1:WIDTH];
            c_d    = |acc_step[2*WIDTH-1:WIDTH];
            v_d    = 1'b0;
            z_d    = (acc_step == '0);
            done_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            done_q <= 1'b0;
            y_q    <= '0;
            yhi_q  <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b1;
        end else begin
            pend_q <= pend_d;
            done_q <= done_d;
            y_q    <= y_d;
            yhi_q  <= yhi_d;
            c_q    <= c_d;
            v_q    <= v_d;
            z_q    <= z_d;
        end
    end

    assign Y    = y_q;
    assign Y_HI = yhi_q;
    assign C    = c_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] S;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Y;
    logic [3:0] Y_HI;
    logic       C;
    logic       V;
    logic       Z;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    alu_seq #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .S     (S),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .Y_HI  (Y_HI),
        .C     (C),
        .V     (V),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] s;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Drive a request for one edge, then sample after the following edge.
    task automatic run_op(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        S = s; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{3'b000, 4'b1010, 4'd0,    4'b0101, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 4'b0011, 4'd0,    4'b1100, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 4'd9,    4'd12,   4'b0101, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'b001, 4'd4,    4'd5,    4'b1001, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'b010, 4'd7,    4'd5,    4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b010, 4'd5,    4'd7,    4'b1110, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 4'd3,    4'd3,    4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b011, 4'd5,    4'd0,    4'b1010, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'b011, 4'd3,    4'd0,    4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b001, 4'd15,   4'd1,    4'b0000, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b010, 4'd8,    4'd1,    4'b0111, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; S = 3'd0; A = 4'd0; B = 4'd0;
        #12;
        chk("reset_Y",    {4'd0, Y},    8'h00);
        chk("reset_Y_HI", {4'd0, Y_HI}, 8'h00);
        chk("reset_C",    {7'd0, C},    8'h00);
        chk("reset_V",    {7'd0, V},    8'h00);
        chk("reset_Z",    {7'd0, Z},    8'h01);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        chk("reset_done", {7'd0, done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_done", i), {7'd0, done}, 8'h01);
            chk($sformatf("vec%0d_Y", i),    {4'd0, Y},    {4'd0, vecs[i].y});
            chk($sformatf("vec%0d_Y_HI", i), {4'd0, Y_HI}, 8'h00);
            chk($sformatf("vec%0d_C", i),    {7'd0, C},    {7'd0, vecs[i].c});
            chk($sformatf("vec%0d_V", i),    {7'd0, V},    {7'd0, vecs[i].v});
            chk($sformatf("vec%0d_Z", i),    {7'd0, Z},    {7'd0, vecs[i].z});
            if (i == 0) begin
                @(negedge clk);
                chk("done_one_cycle", {7'd0, done}, 8'h00);
                chk("result_held",    {4'd0, Y},    8'h05);
            end
        end

        // Back-to-back single-cycle ops with start held high.
        @(negedge clk);
        S = 3'b001; A = 4'd1; B = 4'd2; start = 1'b1;
        @(negedge clk);
        S = 3'b010; A = 4'd7; B = 4'd5;
        @(negedge clk);
        chk("b2b0_done", {7'd0, done}, 8'h01);
        chk("b2b0_Y",    {4'd0, Y},    8'h03);
        S = 3'b110; A = 4'b1111; B = 4'b0101;
        @(negedge clk);
        start = 1'b0;
        chk("b2b1_done", {7'd0, done}, 8'h01);
        chk("b2b1_Y",    {4'd0, Y},    8'h02);
        @(negedge clk);
        chk("b2b2_done", {7'd0, done}, 8'h01);
        chk("b2b2_Y",    {4'd0, Y},    8'h0a);
        @(negedge clk);
        chk("b2b_end_done", {7'd0, done}, 8'h00);

`ifdef ALU_SEQ_MUL_EN
        // Multiply 13*11 = 143, with a disturbing start pulse while busy.
        @(negedge clk);
        S = 3'b111; A = 4'd13; B = 4'd11; start = 1'b1;
        @(negedge clk);
        chk("mul_busy0", {7'd0, busy}, 8'h01);
        chk("mul_done0", {7'd0, done}, 8'h00);
        S = 3'b001; A = 4'd0; B = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("mul_busy1", {7'd0, busy}, 8'h01);
        chk("mul_done1", {7'd0, done}, 8'h00);
        @(negedge clk);
        chk("mul_busy2", {7'd0, busy}, 8'h01);
        chk("mul_done2", {7'd0, done}, 8'h00);
        @(negedge clk);
        chk("mul_busy3", {7'd0, busy}, 8'h01);
        chk("mul_done3", {7'd0, done}, 8'h00);
        @(negedge clk);
        chk("mul_busy4", {7'd0, busy}, 8'h00);
        chk("mul_done",  {7'd0, done}, 8'h01);
        chk("mul_Y",     {4'd0, Y},    8'h0f);
        chk("mul_Y_HI",  {4'd0, Y_HI}, 8'h08);
        chk("mul_C",     {7'd0, C},    8'h01);
        chk("mul_V",     {7'd0, V},    8'h00);
        chk("mul_Z",     {7'd0, Z},    8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mul_no_extra_done%0d", k), {7'd0, done}, 8'h00);
            chk($sformatf("mul_hold_Y_HI%0d", k),     {4'd0, Y_HI}, 8'h08);
        end

        // Multiply 2*3, with an add accepted on the edge that retires it.
        @(negedge clk);
        S = 3'b111; A = 4'd2; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        S = 3'b001; A = 4'd2; B = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mul2_done", {7'd0, done}, 8'h01);
        chk("mul2_Y",    {4'd0, Y},    8'h06);
        chk("mul2_Y_HI", {4'd0, Y_HI}, 8'h00);
        chk("mul2_C",    {7'd0, C},    8'h00);
        @(negedge clk);
        chk("after_mul_add_done", {7'd0, done}, 8'h01);
        chk("after_mul_add_Y",    {4'd0, Y},    8'h04);
        chk("after_mul_add_busy", {7'd0, busy}, 8'h00);

        // Reset two cycles into a multiply.
        @(negedge clk);
        S = 3'b111; A = 4'd13; B = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {7'd0, busy}, 8'h00);
        chk("abort_done", {7'd0, done}, 8'h00);
        chk("abort_Y",    {4'd0, Y},    8'h00);
        chk("abort_Z",    {7'd0, Z},    8'h01);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_no_done%0d", k), {7'd0, done}, 8'h00);
            if (k == 0) rst_n = 1'b1;
        end
        run_op(3'b001, 4'd1, 4'd1);
        chk("post_reset_done", {7'd0, done}, 8'h01);
        chk("post_reset_Y",    {4'd0, Y},    8'h02);
`else
        // Opcode 111 without the multiplier: single-cycle zero result.
        @(negedge clk);
        S = 3'b111; A = 4'd15; B = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nomul_busy0", {7'd0, busy}, 8'h00);
        @(negedge clk);
        chk("nomul_done", {7'd0, done}, 8'h01);
        chk("nomul_busy", {7'd0, busy}, 8'h00);
        chk("nomul_Y",    {4'd0, Y},    8'h00);
        chk("nomul_Y_HI", {4'd0, Y_HI}, 8'h00);
        chk("nomul_C",    {7'd0, C},    8'h00);
        chk("nomul_V",    {7'd0, V},    8'h00);
        chk("nomul_Z",    {7'd0, Z},    8'h01);
        @(negedge clk);
        chk("nomul_done_pulse", {7'd0, done}, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
